// File: rtl/fc_activation_argmax.sv
// Post-FC activation block: ReLU + requantizing shift + unsigned saturation,
// two-stage pipeline with per-pass node indexing and running argmax.
module fc_activation_argmax #(
  parameter int unsigned IN_DATA_WITDH  = 9,
  parameter int unsigned OUT_DATA_WIDTH = 8,
  parameter int unsigned NUM_NODE       = 10,
  parameter int unsigned SHIFT          = 4,
  localparam int unsigned ACC_W = 4 * IN_DATA_WITDH,
  localparam int unsigned IDX_W = (NUM_NODE > 1) ? $clog2(NUM_NODE) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_run,
  input  logic                      i_valid,
  input  logic signed [ACC_W-1:0]   i_acc,
  output logic                      o_valid,
  output logic [OUT_DATA_WIDTH-1:0] o_node,
  output logic [IDX_W-1:0]          o_node_idx,
  output logic                      o_done,
  output logic [IDX_W-1:0]          o_max_idx,
  output logic [OUT_DATA_WIDTH-1:0] o_max_val,
  output logic                      o_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0]          r_cnt;
  logic                      r_s1_vld;
  logic [ACC_W-1:0]          r_s1_val;
  logic [IDX_W-1:0]          r_s1_idx;

  logic                      w_accept;
  logic                      w_err_in;
  logic                      w_last_out;
  logic signed [ACC_W-1:0]   w_shift;
  logic [ACC_W-1:0]          w_s1;
  logic [OUT_DATA_WIDTH-1:0] w_sat;

  // Stage-1 requantize + ReLU, stage-2 saturation
  assign w_shift = i_acc >>> SHIFT;
  assign w_s1    = i_acc[ACC_W-1] ? '0 : w_shift;
  assign w_sat   = (|r_s1_val[ACC_W-1:OUT_DATA_WIDTH]) ? '1 : r_s1_val[OUT_DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // i_run overrides everything, including a coincident i_valid
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_in    = 1'b0;
    w_last_out  = r_s1_vld && (r_s1_idx == LAST_IDX);
    if (i_run) begin
      w_state_nxt = S_COLLECT;
    end else begin
      case (r_state)
        S_COLLECT: begin
          w_accept = i_valid;
          if (i_valid && (r_cnt == LAST_IDX)) w_state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          w_err_in = i_valid;
          if (w_last_out) w_state_nxt = S_IDLE;
        end
        default: begin
          w_err_in = i_valid;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_val   <= '0;
      r_s1_idx   <= '0;
      o_valid    <= 1'b0;
      o_node     <= '0;
      o_node_idx <= '0;
      o_done     <= 1'b0;
      o_max_idx  <= '0;
      o_max_val  <= '0;
      o_err      <= 1'b0;
    end else if (i_run) begin
      r_cnt     <= '0;
      r_s1_vld  <= 1'b0;
      o_valid   <= 1'b0;
      o_done    <= 1'b0;
      o_max_idx <= '0;
      o_max_val <= '0;
      o_err     <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_val <= w_s1;
        r_s1_idx <= r_cnt;
        r_cnt    <= (r_cnt == LAST_IDX) ? '0 : r_cnt + IDX_W'(1);
      end
      o_valid <= r_s1_vld;
      o_done  <= w_last_out;
      // Argmax tracks the same edge as o_node so it is current on o_done
      if (r_s1_vld) begin
        o_node     <= w_sat;
        o_node_idx <= r_s1_idx;
        if ((r_s1_idx == '0) || (w_sat > o_max_val)) begin
          o_max_idx <= r_s1_idx;
          o_max_val <= w_sat;
        end
      end
      if (w_err_in) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_activation_argmax.sv
// Self-checking bench for fc_activation_argmax: directed vector table,
// hand-written run/reset/overflow sequences, and randomized passes vs. a model.
module tb_fc_activation_argmax;

  localparam int NN = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_run;
  logic        i_valid;
  logic [35:0] i_acc;
  logic        o_valid;
  logic [7:0]  o_node;
  logic [1:0]  o_node_idx;
  logic        o_done;
  logic [1:0]  o_max_idx;
  logic [7:0]  o_max_val;
  logic        o_err;

  fc_activation_argmax #(
    .IN_DATA_WITDH(9), .OUT_DATA_WIDTH(8), .NUM_NODE(NN), .SHIFT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_valid(i_valid), .i_acc(i_acc),
    .o_valid(o_valid), .o_node(o_node), .o_node_idx(o_node_idx), .o_done(o_done),
    .o_max_idx(o_max_idx), .o_max_val(o_max_val), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle
  int obs_cyc[$];
  int obs_node[$];
  int obs_idx[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int done_midx = 0;
  int done_mval = 0;
  always @(negedge clk) begin
    if (o_valid) begin
      obs_cyc.push_back(cyc);
      obs_node.push_back(int'(o_node));
      obs_idx.push_back(int'(o_node_idx));
    end
    if (o_done) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc;
      done_midx = int'(o_max_idx);
      done_mval = int'(o_max_val);
    end
  end

  typedef struct {
    longint acc[4];
    int     node[4];
    int     midx;
    int     mval;
    int     gap;
  } vec_t;

  vec_t   vt[5];
  longint pa[4];
  int     exp_node[4];
  int     exp_midx;
  int     exp_mval;
  int     dcyc[8];
  int     obs_base;
  int     done_base;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_node(input longint a);
    longint v;
    if (a < 0) return 0;
    v = a / 16;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  function automatic longint rand_acc();
    logic signed [35:0] t;
    case ($urandom_range(0, 2))
      0:       return longint'($urandom_range(0, 5000)) - 64'sd1000;
      1:       return longint'($urandom_range(0, 4200));
      default: begin
        t = 36'({$urandom, $urandom});
        return longint'(t);
      end
    endcase
  endfunction

  task automatic mark();
    obs_base  = obs_cyc.size();
    done_base = done_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pulse();
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
  endtask

  task automatic feed(input int gap, input int nin);
    for (int n = 0; n < nin; n++) begin
      i_valid = 1'b1;
      i_acc   = 36'(pa[n % 4]);
      dcyc[n] = cyc;
      tick();
      i_valid = 1'b0;
      repeat (gap) tick();
    end
    repeat (5) tick();
  endtask

  task automatic check_pass(input string tag, input int exp_err);
    int nout;
    nout = obs_cyc.size() - obs_base;
    chk({tag, "_nout"}, nout, NN);
    for (int n = 0; n < NN; n++) begin
      if (n < nout) begin
        chk($sformatf("%s_node%0d", tag, n), obs_node[obs_base + n], exp_node[n]);
        chk($sformatf("%s_idx%0d", tag, n), obs_idx[obs_base + n], n);
        chk($sformatf("%s_lat%0d", tag, n), obs_cyc[obs_base + n] - dcyc[n], 2);
      end
    end
    chk({tag, "_done_cnt"}, done_cnt - done_base, 1);
    if (nout > 0) chk({tag, "_done_cyc"}, done_cyc, obs_cyc[obs_cyc.size() - 1]);
    chk({tag, "_done_midx"}, done_midx, exp_midx);
    chk({tag, "_done_mval"}, done_mval, exp_mval);
    chk({tag, "_hold_midx"}, o_max_idx, exp_midx);
    chk({tag, "_hold_mval"}, o_max_val, exp_mval);
    chk({tag, "_err"}, o_err, exp_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_node"}, o_node, 0);
    chk({tag, "_idx"}, o_node_idx, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_midx"}, o_max_idx, 0);
    chk({tag, "_mval"}, o_max_val, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  task automatic load_vec(input int k);
    for (int n = 0; n < NN; n++) begin
      pa[n]       = vt[k].acc[n];
      exp_node[n] = vt[k].node[n];
    end
    exp_midx = vt[k].midx;
    exp_mval = vt[k].mval;
  endtask

  initial begin
    vt[0].acc = '{64'sd256, -64'sd5, 64'sd100000, 64'sd48};
    vt[0].node = '{16, 0, 255, 3};  vt[0].midx = 2; vt[0].mval = 255; vt[0].gap = 0;
    vt[1].acc = '{64'sd80, 64'sd80, 64'sd32, 64'sd80};
    vt[1].node = '{5, 5, 2, 5};     vt[1].midx = 0; vt[1].mval = 5;   vt[1].gap = 0;
    vt[2].acc = '{64'sd15, 64'sd16, -64'sd17, 64'sd4095};
    vt[2].node = '{0, 1, 0, 255};   vt[2].midx = 3; vt[2].mval = 255; vt[2].gap = 1;
    vt[3].acc = '{-64'sd16, -64'sd1, -64'sd100000, -64'sd34359738368};
    vt[3].node = '{0, 0, 0, 0};     vt[3].midx = 0; vt[3].mval = 0;   vt[3].gap = 2;
    vt[4].acc = '{64'sd4096, 64'sd4080, 64'sd17, 64'sd34359738367};
    vt[4].node = '{255, 255, 1, 255}; vt[4].midx = 0; vt[4].mval = 255; vt[4].gap = 0;

    reset_n = 1'b0;
    i_run   = 1'b0;
    i_valid = 1'b0;
    i_acc   = '0;
    repeat (3) tick();
    chk_zero("rst");
    reset_n = 1'b1;
    tick();

    // Directed table
    for (int k = 0; k < 5; k++) begin
      load_vec(k);
      mark();
      run_pulse();
      feed(vt[k].gap, NN);
      check_pass($sformatf("vec%0d", k), 0);
    end

    // Fifth input after a full pass is rejected and flags a sticky error
    load_vec(0);
    mark();
    run_pulse();
    feed(0, 5);
    check_pass("extra", 1);
    repeat (4) tick();
    chk("err_sticky", o_err, 1);
    run_pulse();
    chk("err_clr", o_err, 0);

    // i_run coincident with the third input restarts the pass
    mark();
    run_pulse();
    i_valid = 1'b1;
    i_acc   = 36'(64'sd1000);
    tick();
    i_acc = 36'(64'sd2000);
    tick();
    i_run = 1'b1;
    i_acc = 36'(64'sd3000);
    tick();
    i_run   = 1'b0;
    i_valid = 1'b0;
    repeat (3) tick();
    chk("restart_nout", obs_cyc.size() - obs_base, 1);
    chk("restart_done", done_cnt - done_base, 0);
    load_vec(1);
    mark();
    feed(0, NN);
    check_pass("restart", 0);

    // Reset mid-pass clears everything immediately and stays quiet afterwards
    run_pulse();
    i_valid = 1'b1;
    i_acc   = 36'(64'sd4000);
    tick();
    i_acc = 36'(64'sd800);
    tick();
    i_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) tick();
    reset_n = 1'b1;
    mark();
    repeat (6) tick();
    chk("midrst_nout", obs_cyc.size() - obs_base, 0);
    chk("midrst_ndone", done_cnt - done_base, 0);

    // Randomized passes against the model
    for (int r = 0; r < 25; r++) begin
      for (int n = 0; n < NN; n++) begin
        pa[n]       = rand_acc();
        exp_node[n] = model_node(pa[n]);
      end
      exp_midx = 0;
      exp_mval = exp_node[0];
      for (int n = 1; n < NN; n++) begin
        if (exp_node[n] > exp_mval) begin
          exp_midx = n;
          exp_mval = exp_node[n];
        end
      end
      mark();
      run_pulse();
      feed(int'($urandom_range(0, 2)), NN);
      check_pass($sformatf("rnd%0d", r), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_activation_argmax.md
FC_ACTIVATION_ARGMAX -- requirements
Module: fc_activation_argmax

Interface
REQ-001 Parameter IN_DATA_WITDH, default 9: operand width of the upstream fully-connected core; accumulator input width is 4*IN_DATA_WITDH (36).
REQ-002 Parameter OUT_DATA_WIDTH, default 8: unsigned activation output width.
REQ-003 Parameter NUM_NODE, default 10: output nodes per layer pass.
REQ-004 Parameter SHIFT, default 4: arithmetic right-shift (requantization) amount.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_run  input  1  one-cycle pulse; starts a new layer pass, clears all pass state.
REQ-008 i_valid  input  1  i_acc valid this cycle (driven from upstream o_valid).
REQ-009 i_acc  input  4*IN_DATA_WITDH  signed accumulated node result.
REQ-010 o_valid  output  1  o_node/o_node_idx valid this cycle.
REQ-011 o_node  output  OUT_DATA_WIDTH  unsigned activated, requantized node value.
REQ-012 o_node_idx  output  clog2(NUM_NODE)  index of o_node within the pass.
REQ-013 o_done  output  1  one-cycle pulse, pass complete.
REQ-014 o_max_idx  output  clog2(NUM_NODE)  argmax index, valid from o_done until next i_run.
REQ-015 o_max_val  output  OUT_DATA_WIDTH  value at o_max_idx, same validity.
REQ-016 o_err  output  1  sticky: i_valid received outside COLLECT; cleared by i_run or reset.

Function
REQ-017 FSM states IDLE, COLLECT, DRAIN; IDLE after reset.
REQ-018 i_run in any state -> COLLECT next cycle; clears node counter, pipeline valid bits, argmax registers, o_err; i_valid in the same cycle is dropped.
REQ-019 COLLECT: each i_valid accepted, counter increments; on NUM_NODE-th accept -> DRAIN.
REQ-020 DRAIN: when last node leaves pipeline, o_done pulses in same cycle as its o_valid -> IDLE.
REQ-021 i_valid in IDLE or DRAIN: input discarded, o_err set next cycle.
REQ-022 Datapath: 2 registered stages; o_valid exactly 2 cycles after accepted i_valid; back-to-back inputs give back-to-back outputs, no bubbles.
REQ-023 Stage 1: s = i_acc >>> SHIFT (sign-preserving); if i_acc < 0, s = 0 (ReLU).
REQ-024 Stage 2: o_node = min(s, 2^OUT_DATA_WIDTH - 1) (unsigned saturation).
REQ-025 o_node_idx = accept order 0..NUM_NODE-1, carried through pipeline with data.
REQ-026 Argmax updated on each o_valid: replace only if o_node strictly greater than current max (ties keep lowest index); first node of pass always loads.
REQ-027 o_max_idx/o_max_val reflect the final node on the o_done cycle and hold until i_run or reset.
REQ-028 No input backpressure; block accepts one i_valid per cycle in COLLECT.
REQ-029 o_node and o_node_idx hold last value when o_valid low.

Reset
REQ-030 reset_n low: immediately force IDLE, counter 0, pipeline valids 0, o_valid 0, o_node 0, o_node_idx 0, o_done 0, o_max_idx 0, o_max_val 0, o_err 0.
REQ-031 Reset mid-pass discards all in-flight data; no o_valid or o_done after release until a new i_run.

Verification (NUM_NODE=4, SHIFT=4, OUT_DATA_WIDTH=8)
REQ-032 i_run, then i_acc 256, -5, 100000, 48 on 4 consecutive cycles -> o_node 16, 0, 255, 3 with idx 0..3 at +2..+5 cycles; o_done with idx 3; o_max_idx 2, o_max_val 255.
REQ-033 Ties: i_acc 80, 80, 32, 80 -> o_node 5,5,2,5; o_max_idx 0, o_max_val 5.
REQ-034 i_valid gapped (one idle cycle between each of 4 inputs) -> each o_valid exactly 2 cycles after its input; single o_done on final output.
REQ-035 Fifth i_valid after 4 accepted -> no 5th o_valid, o_err 1 and sticky; next i_run -> o_err 0.
REQ-036 i_run coincident with 3rd i_valid -> that input dropped, counter 0, earlier in-flight outputs suppressed; following 4 inputs complete normally.
REQ-037 reset_n asserted after 2 accepted inputs -> all outputs 0 immediately; after release, no o_valid/o_done until i_run.
